tff_count_ctrl: RTL

Controller that sequences a WIDTH-bit bank of T flip-flops as a programmable up/down step counter. Per cycle it computes the per-bit toggle vector for the bank: parallel load via XOR, or counting a requested number of steps. It uses a start/busy/done handshake. It sits above the T flip-flop cell and exposes the bank state on q.

---
 rtl/tff_count_ctrl_pkg.sv | 14 +
 rtl/tff_count_ctrl_if.sv | 34 +++
 rtl/tff_count_ctrl_bank.sv | 21 ++
 rtl/tff_count_ctrl.sv | 136 +++++++++++++
 4 files changed

// File: rtl/tff_count_ctrl_pkg.sv
// Shared types for the T flip-flop step counter controller: FSM state
// encoding and count-direction constants.
package tff_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ctrl_state_e;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/tff_count_ctrl_if.sv
// Request/status bundle of tff_count_ctrl. The pause wire exists only when
// TFF_CTRL_PAUSE_EN is defined.
interface tff_count_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             dir;
    logic [WIDTH-1:0] steps;
    logic             load;
    logic [WIDTH-1:0] load_val;
`ifdef TFF_CTRL_PAUSE_EN
    logic             pause;
`endif
    logic [WIDTH-1:0] toggle;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;

    modport master (
        output start, dir, steps, load, load_val,
`ifdef TFF_CTRL_PAUSE_EN
        output pause,
`endif
        input  toggle, q, busy, done
    );

    modport slave (
        input  start, dir, steps, load, load_val,
`ifdef TFF_CTRL_PAUSE_EN
        input  pause,
`endif
        output toggle, q, busy, done
    );
endinterface

// File: rtl/tff_count_ctrl_bank.sv
// Bank of WIDTH T flip-flops sharing one clock and an active-low async reset;
// each bit inverts on the rising edge when its toggle bit is set.
module tff_bank #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] toggle,
    output logic [WIDTH-1:0] q
);

    // T flip-flop update for every bit of the bank
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= {WIDTH{1'b0}};
        end else begin
            q <= q ^ toggle;
        end
    end

endmodule

// File: rtl/tff_count_ctrl.sv
// Start/busy/done controller that drives a tff_bank as an up/down step
// counter with parallel load. Optional run pause: TFF_CTRL_PAUSE_EN.
module tff_count_ctrl
    import tff_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    tff_count_ctrl_if.slave     bus
);

    localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

    ctrl_state_e      state_r;
    logic             dir_r;
    logic [WIDTH-1:0] remaining_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] toggle_s;
    logic [WIDTH-1:0] q_s;
    logic             pause_s;

`ifdef TFF_CTRL_PAUSE_EN
    assign pause_s = bus.pause;
`else
    assign pause_s = 1'b0;
`endif

    // Toggle vector: XOR-load in IDLE, ripple carry/borrow chain in RUN
    always_comb begin
        logic carry_v;
        toggle_s = ZERO_C;
        carry_v  = 1'b1;
        case (state_r)
            IDLE: begin
                if (bus.load) begin
                    toggle_s = q_s ^ bus.load_val;
                end else begin
                    toggle_s = ZERO_C;
                end
            end
            RUN: begin
                if (pause_s) begin
                    toggle_s = ZERO_C;
                end else begin
                    // a bit flips when every lower bit is 1 (up) or 0 (down)
                    for (int i = 0; i < WIDTH; i++) begin
                        toggle_s[i] = carry_v;
                        if (dir_r == DIR_UP) begin
                            carry_v = carry_v & q_s[i];
                        end else begin
                            carry_v = carry_v & ~q_s[i];
                        end
                    end
                end
            end
            DONE: begin
                toggle_s = ZERO_C;
            end
            default: begin
                toggle_s = ZERO_C;
            end
        endcase
    end

    // Run sequencer with registered busy/done status
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            dir_r       <= DIR_DOWN;
            remaining_r <= ZERO_C;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.load) begin
                        state_r <= IDLE;
                    end else if (bus.start) begin
                        dir_r       <= bus.dir;
                        remaining_r <= bus.steps;
                        if (bus.steps != ZERO_C) begin
                            state_r <= RUN;
                            busy_r  <= 1'b1;
                        end else begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    if (pause_s) begin
                        state_r <= RUN;
                    end else begin
                        remaining_r <= remaining_r - ONE_C;
                        if (remaining_r == ONE_C) begin
                            state_r <= DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= RUN;
                        end
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    tff_bank #(
        .WIDTH (WIDTH)
    ) u_bank (
        .clk    (clk),
        .rst    (rst),
        .toggle (toggle_s),
        .q      (q_s)
    );

    assign bus.toggle = toggle_s;
    assign bus.q      = q_s;
    assign bus.busy   = busy_r;
    assign bus.done   = done_r;

endmodule
